// File: rtl/fp_alu_ctrl_if.sv
// Command and result streams between fp_alu_ctrl and its producer/consumer.
// The controller is the slave; the environment driving commands is the master.
interface fp_alu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_opcode;
  logic        in_add_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [1:0]  out_opcode;

  modport master (
    output in_valid, in_a, in_b, in_opcode, in_add_sub, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_opcode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, in_add_sub, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_opcode
  );
endinterface

// File: rtl/fp_alu.sv
// fp_alu itself comes from the shared datapath library.
// Its operands are sequenced by fp_alu_ctrl.sv.

// File: rtl/fp_alu_ctrl.sv
// Sequencer for the combinational fp_alu: FIFO-buffered commands, stable
// operands for a settle window, registered result with IEEE class flags.
module fp_alu_ctrl #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_alu_ctrl_if.slave           bus,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [1:0]             alu_opcode,
  output logic                   alu_add_sub,
  input  logic [31:0]            alu_result,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SL = SETTLE - 1;
  localparam logic [AW:0]   FULL_N   = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [SW-1:0] SET_ONE  = 1;
  localparam logic [SW-1:0] SET_LAST = SL[SW-1:0];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        add_sub;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [SW-1:0] settle_cnt;
  state_t        state;
  state_t        state_nx;
  logic          push;
  logic          pop;
  logic          capture;
  logic          full;
  logic [31:0]   cap_word;

  function automatic logic [3:0] classify(input logic [31:0] w);
    logic e_max;
    logic e_zero;
    logic m_zero;
    e_max  = &w[30:23];
    e_zero = ~|w[30:23];
    m_zero = ~|w[22:0];
    return {e_max && !m_zero, e_max && m_zero, e_zero && m_zero, w[31]};
  endfunction

  assign full         = (count == FULL_N);
  assign bus.in_ready = !full && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem[rd_ptr];
  assign busy         = (state != IDLE) || (count != '0);
  // Reserved opcode yields a canonical quiet NaN whatever fp_alu drives.
  assign cap_word     = (alu_opcode == 2'b11) ? 32'h7FC00000 : alu_result;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == SET_LAST) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_valid && bus.out_ready) begin
          if (count != '0) begin
            pop      = 1'b1;
            state_nx = DRIVE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b,
                       op: bus.in_opcode, add_sub: bus.in_add_sub};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      settle_cnt     <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_opcode     <= '0;
      alu_add_sub    <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_flags  <= '0;
      bus.out_opcode <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        alu_a       <= head.a;
        alu_b       <= head.b;
        alu_opcode  <= head.op;
        alu_add_sub <= head.add_sub;
        settle_cnt  <= '0;
      end else if (state == DRIVE) begin
        settle_cnt <= settle_cnt + SET_ONE;
      end
      if (capture) begin
        bus.out_valid  <= 1'b1;
        bus.out_result <= cap_word;
        bus.out_flags  <= classify(cap_word);
        bus.out_opcode <= alu_opcode;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fp_alu_ctrl.md
# fp_alu_ctrl

Sequencing front-end for the combinational `fp_alu`. It accepts floating-point commands (operands, opcode, add_sub) over a valid/ready interface and buffers them in a small FIFO. It presents one command at a time to `fp_alu` with stable operands, waits a fixed settle window, then registers the result with IEEE-754 class flags. The registered result is offered downstream over a valid/ready interface.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `SETTLE`, 2: cycles `fp_alu` inputs are held stable before the result is captured (≥1).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: command present.
- `in_ready` out 1: FIFO can accept; equals `!full && !rst`.
- `in_a`, `in_b` in 32: single-precision operands.
- `in_opcode` in 2: 00 add/sub, 01 mul, 10 div, 11 reserved.
- `in_add_sub` in 1: 0 add, 1 subtract (used only with opcode 00).
- `alu_a`, `alu_b` out 32: to `fp_alu` `a`/`b`.
- `alu_opcode` out 2 and `alu_add_sub` out 1: to `fp_alu`.
- `alu_result` in 32: from `fp_alu` `result`.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `out_result` out 32: registered result.
- `out_flags` out 4: {nan, inf, zero, sign} of `out_result`.
- `out_opcode` out 2: opcode of the command that produced `out_result`.
- `count` out log2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: state != IDLE or count != 0.

## Operation
- **FIFO**
  - Push on `in_valid && in_ready`.
  - Pop only by the FSM.
  - Simultaneous push and pop leaves `count` unchanged.
  - Entries are 67 bits {a, b, opcode, add_sub}; order is strictly preserved.
- **Operand register** drives `alu_*`.
  - Loaded only at pop.
  - Holds its value through DRIVE and HOLD so `fp_alu` inputs never change mid-evaluation.
- **FSM states**
  - IDLE: if `count != 0`, pop into the operand register, clear `settle_cnt`, go to DRIVE.
  - DRIVE: increment `settle_cnt`. At the edge where `settle_cnt == SETTLE-1`, capture `alu_result` into `out_result`, capture the opcode into `out_opcode`, compute the flags, set `out_valid`, and go to HOLD.
  - HOLD: wait for `out_valid && out_ready`. At that edge, clear `out_valid`. If `count != 0`, pop and go to DRIVE (no IDLE bubble); otherwise go to IDLE.
- **Reserved opcode 11**
  - Passes through DRIVE with the same latency.
  - Capture substitutes `32'h7FC00000` for `alu_result`, so flags = 1000.
- **Flags**, from the captured word:
  - nan = exp==8'hFF && mant!=0
  - inf = exp==8'hFF && mant==0
  - zero = exp==0 && mant==0
  - sign = bit 31
  - Denormals set no flag except sign.
- **Capacity with `out_ready` held low:** exactly DEPTH+1 commands are accepted (one captured or in flight, DEPTH in the FIFO). `in_ready` then stays low.

## Timing
- **Reset values:**
  - state IDLE, FIFO empty, `count` 0
  - `out_valid` 0, `out_result` 0, `out_flags` 0, `out_opcode` 0
  - `alu_a`/`alu_b`/`alu_opcode`/`alu_add_sub` 0
  - `busy` 0, `in_ready` 0 while `rst` is high and 1 the cycle after
- **Reset mid-operation:** all queued and in-flight commands are discarded silently; no partial output.
- **Latency, idle block:**
  - Command accepted at edge E0.
  - Popped at E1.
  - Captured at E1+SETTLE.
  - `out_valid` is high in the cycle following E1+SETTLE (defaults: 3 edges after acceptance).
- **Throughput:** one result per SETTLE+1 cycles when `out_ready` is held high (HOLD lasts one cycle, then DRIVE).
- **Downstream stability:**
  - `out_result`, `out_flags` and `out_opcode` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake.
- **`in_ready`:**
  - Depends only on registered `count` and `rst`, never combinationally on `in_valid`.
  - A push while full is impossible by construction.
- **Simultaneous events:** a push in the same cycle as the HOLD→DRIVE pop is legal; the popped entry is the oldest, never the one being pushed, unless the FIFO was empty.

## Test plan
- **Reset:** assert `rst` 2 cycles with `in_valid`=1 → no push, `count`=0, `out_valid`=0, all outputs 0; `in_ready`=1 the cycle after release.
- **Single add:** a=3F800000, b=40000000, op 00, add_sub 0, `out_ready`=1 → `out_valid` 3 edges after acceptance; result 40400000, flags 0000, `out_opcode` 00; `alu_a` stable for the whole DRIVE window.
- **Back-to-back stream:** mul 40000000×C0400000, then sub 3F800000−3F800000 → results in order: C0C00000 with flags 0001, then 00000000 with flags 0010; spacing SETTLE+1 cycles.
- **Reserved opcode:** op 11 with any operands → result 7FC00000, flags 1000, same latency as the single add.
- **Backpressure:** `out_ready`=0, push 7 back-to-back → exactly 5 accepted, then `in_ready`=0 and `count`=4; outputs held constant. Raise `out_ready` → 5 results in push order, `in_ready` reasserts after the first handshake.
- **Reset mid-flight:** 3 queued plus one in DRIVE, pulse `rst` → next cycle `count`=0, `out_valid`=0; a subsequent new command produces only its own result.
